// File: rtl/sdram_model.sv
// sdram_model: cycle-accurate responder for a single 16-bit SDRAM command bus.
// Decodes {cs,ras,cas,we} every rising edge, tracks init sequencing and per-bank
// row state, stores write data in an internal array and returns read data after
// the programmed CAS latency. The first protocol violation is latched in err_code.
module sdram_model #(
    parameter int MEM_AW       = 12,
    parameter int INIT_REFRESH = 2,
    parameter int RCD          = 1,
    parameter int TREFI_MAX    = 1248
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [15:0] sd_data,
    input  logic [11:0] sd_addr,
    input  logic [1:0]  sd_dqm,
    input  logic [1:0]  sd_ba,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    output logic        init_done,
    output logic [2:0]  mode_cl,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] refresh_count
);

    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

    // RCD counter is loaded with the number of further edges that must pass
    // before a column command is legal; zero means "legal on the next edge".
    localparam logic [3:0]    RCD_LOAD   = (RCD > 1) ? 4'(RCD - 1) : 4'd0;
    localparam int            TW         = $clog2(TREFI_MAX + 2);
    localparam logic [TW-1:0] TREFI_L    = TW'(TREFI_MAX);
    localparam logic [TW-1:0] TREFI_SAT  = TW'(TREFI_MAX + 1);
    localparam logic [7:0]    INIT_REF_L = 8'(INIT_REFRESH);

    typedef enum logic [1:0] {
        ST_UNINIT     = 2'd0,
        ST_PRECHARGED = 2'd1,
        ST_READY      = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [3:0]  cmd;
    logic        do_active, do_read, do_write, do_pre, do_ref, do_mode, init_ref;
    logic        cmd_err;
    logic [2:0]  cmd_err_code;
    logic        mode_ok;

    logic [3:0]        open_all;
    logic [3:0][11:0]  row_all;
    logic [3:0][3:0]   rcd_all;
    logic              sel_open;
    logic              any_open;
    logic [3:0]        sel_rcd;

    logic [7:0]     init_cnt_q;
    logic [TW-1:0]  trefi_q;
    logic           trefi_hit;
    logic [2:0]     mode_cl_q;
    logic           err_q;
    logic [2:0]     err_code_q;
    logic [15:0]    refresh_count_q;

    logic [21:0]        addr_full;
    logic [MEM_AW-1:0]  mem_idx;
    logic [15:0]        mem_q [0:(1 << MEM_AW) - 1];
    logic [15:0]        rd_data_q, rd_d1_q, rd_d2_q;
    logic [2:0]         rd_vld_q;
    logic               bus_en;
    logic [15:0]        bus_val;

    assign cmd      = {sd_cs, sd_ras, sd_cas, sd_we};
    assign sel_open = open_all[sd_ba];
    assign sel_rcd  = rcd_all[sd_ba];
    assign any_open = |open_all;
    assign mode_ok  = ((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) && (sd_addr[2:0] == 3'd0);

    // Word index: low MEM_AW bits of {bank, open row, column}.
    assign addr_full = {sd_ba, row_all[sd_ba], sd_addr[7:0]};
    assign mem_idx   = addr_full[MEM_AW-1:0];

    if (MEM_AW < 22) begin : g_idx_hi
        logic unused_idx_hi;
        assign unused_idx_hi = ^addr_full[21:MEM_AW];
    end

    // Init FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_UNINIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Command decode: legality checks, accepted-command strobes and next state.
    always_comb begin
        state_d      = state_q;
        cmd_err      = 1'b0;
        cmd_err_code = 3'd0;
        do_active    = 1'b0;
        do_read      = 1'b0;
        do_write     = 1'b0;
        do_pre       = 1'b0;
        do_ref       = 1'b0;
        do_mode      = 1'b0;
        init_ref     = 1'b0;
        case (cmd)
            CMD_ACTIVE: begin
                if (state_q != ST_READY) begin
                    cmd_err = 1'b1; cmd_err_code = 3'd1;
                end else if (sel_open) begin
                    cmd_err = 1'b1; cmd_err_code = 3'd4;
                end else begin
                    do_active = 1'b1;
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (state_q != ST_READY) begin
                    cmd_err = 1'b1; cmd_err_code = 3'd1;
                end else if (!sel_open) begin
                    cmd_err = 1'b1; cmd_err_code = 3'd2;
                end else if (sel_rcd != 4'd0) begin
                    cmd_err = 1'b1; cmd_err_code = 3'd3;
                end else if (cmd == CMD_READ) begin
                    do_read = 1'b1;
                end else begin
                    do_write = 1'b1;
                end
            end
            CMD_PRECHARGE: begin
                do_pre = 1'b1;
                if (state_q == ST_UNINIT && sd_addr[10]) begin
                    state_d = ST_PRECHARGED;
                end
            end
            CMD_REFRESH: begin
                if (state_q == ST_PRECHARGED) begin
                    init_ref = 1'b1;
                end else if (state_q == ST_READY) begin
                    if (any_open) begin
                        cmd_err = 1'b1; cmd_err_code = 3'd5;
                    end else begin
                        do_ref = 1'b1;
                    end
                end
            end
            CMD_LOAD_MODE: begin
                if (state_q == ST_UNINIT ||
                    (state_q == ST_PRECHARGED && init_cnt_q < INIT_REF_L)) begin
                    cmd_err = 1'b1; cmd_err_code = 3'd1;
                end else if (state_q == ST_READY && any_open) begin
                    cmd_err = 1'b1; cmd_err_code = 3'd5;
                end else if (!mode_ok) begin
                    cmd_err = 1'b1; cmd_err_code = 3'd6;
                end else begin
                    do_mode = 1'b1;
                    state_d = ST_READY;
                end
            end
            default: ;
        endcase
    end

    // Per-bank open flag, latched row and ACTIVE-to-column spacing counter.
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        logic        open_q, open_d;
        logic [11:0] row_q, row_d;
        logic [3:0]  rcd_q, rcd_d;
        logic        hit;

        assign hit         = (sd_ba == 2'(gi));
        assign open_all[gi] = open_q;
        assign row_all[gi]  = row_q;
        assign rcd_all[gi]  = rcd_q;

        // Bank next state; auto-precharge closes after the access at this edge.
        always_comb begin
            open_d = open_q;
            row_d  = row_q;
            rcd_d  = (rcd_q != 4'd0) ? rcd_q - 4'd1 : 4'd0;
            if (do_active && hit) begin
                open_d = 1'b1;
                row_d  = sd_addr;
                rcd_d  = RCD_LOAD;
            end
            if ((do_read || do_write) && hit && sd_addr[10]) begin
                open_d = 1'b0;
            end
            if (do_pre && (sd_addr[10] || hit)) begin
                open_d = 1'b0;
            end
        end

        // Bank state register.
        always_ff @(posedge clk) begin
            if (reset) begin
                open_q <= 1'b0;
                row_q  <= 12'd0;
                rcd_q  <= 4'd0;
            end else begin
                open_q <= open_d;
                row_q  <= row_d;
                rcd_q  <= rcd_d;
            end
        end
    end

    // Refresh-interval watchdog trips on the edge that would exceed TREFI_MAX.
    assign trefi_hit = (state_q == ST_READY) && !do_ref && (trefi_q == TREFI_L);

    // Init refresh count, refresh interval, mode register and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt_q      <= 8'd0;
            trefi_q         <= '0;
            mode_cl_q       <= 3'd0;
            err_q           <= 1'b0;
            err_code_q      <= 3'd0;
            refresh_count_q <= 16'd0;
        end else begin
            if (state_q == ST_UNINIT) begin
                init_cnt_q <= 8'd0;
            end else if (init_ref && init_cnt_q != 8'hFF) begin
                init_cnt_q <= init_cnt_q + 8'd1;
            end
            if (state_q != ST_READY || do_ref) begin
                trefi_q <= '0;
            end else if (trefi_q != TREFI_SAT) begin
                trefi_q <= trefi_q + 1'b1;
            end
            if (do_ref) begin
                refresh_count_q <= refresh_count_q + 16'd1;
            end
            if (do_mode) begin
                mode_cl_q <= sd_addr[6:4];
            end
            if (!err_q && (cmd_err || trefi_hit)) begin
                err_q      <= 1'b1;
                err_code_q <= cmd_err ? cmd_err_code : 3'd7;
            end
        end
    end

    // Storage array with per-byte write enables and a registered read port.
    always_ff @(posedge clk) begin
        if (!reset && do_write && !sd_dqm[0]) begin
            mem_q[mem_idx][7:0] <= sd_data[7:0];
        end
        if (!reset && do_write && !sd_dqm[1]) begin
            mem_q[mem_idx][15:8] <= sd_data[15:8];
        end
        rd_data_q <= mem_q[mem_idx];
    end

    // Read latency valid bits; an accepted WRITE cancels anything in flight.
    always_ff @(posedge clk) begin
        if (reset || do_write) begin
            rd_vld_q <= 3'b000;
        end else begin
            rd_vld_q <= {rd_vld_q[1:0], do_read};
        end
    end

    // Read latency data stages behind the array output register.
    always_ff @(posedge clk) begin
        rd_d1_q <= rd_data_q;
        rd_d2_q <= rd_d1_q;
    end

    assign bus_en  = ((mode_cl_q == 3'd2) && rd_vld_q[1]) || ((mode_cl_q == 3'd3) && rd_vld_q[2]);
    assign bus_val = (mode_cl_q == 3'd3) ? rd_d2_q : rd_d1_q;
    assign sd_data = bus_en ? bus_val : 16'hzzzz;

    assign init_done     = (state_q == ST_READY);
    assign mode_cl       = mode_cl_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign refresh_count = refresh_count_q;

endmodule

// File: doc/sdram_model.md
# sdram_model

Cycle-accurate, synthesizable responder for the single-chip 16-bit SDRAM command bus driven by the system's SDRAM controller. It decodes CS/RAS/CAS/WE on every clock, tracks per-bank row state, stores data in an internal array, and returns read data after the programmed CAS latency. It is used in simulation and in on-FPGA loopback builds to exercise the controller's init, access and refresh sequencing. It also flags the first protocol violation it sees.

## Interface
- MEM_AW, 12, word-address bits stored; the array index is the low MEM_AW bits of {ba, row[11:0], col[7:0]}.
- INIT_REFRESH, 2, minimum number of AUTO_REFRESH commands required between PRECHARGE-all and LOAD_MODE.
- RCD, 1, minimum clock edges from ACTIVE to READ/WRITE on the same bank.
- TREFI_MAX, 1248, maximum clock cycles allowed between AUTO_REFRESH commands once ready.
- clk  in  1  clock; all SDRAM pins sampled on rising edge.
- reset  in  1  synchronous, active-high.
- sd_data  inout  16  data bus; driven only during read-data cycles, otherwise Z.
- sd_addr  in  12  multiplexed row / column address; A10 selects auto-precharge or precharge-all.
- sd_dqm  in  2  write byte masks; bit1 masks [15:8], bit0 masks [7:0]; 1 = masked.
- sd_ba  in  2  bank select.
- sd_cs, sd_ras, sd_cas, sd_we  in  1 each  command; {cs,ras,cas,we} encodes the command.
- init_done  out  1  high once a valid LOAD_MODE completes the init sequence.
- mode_cl  out  3  programmed CAS latency, 2 or 3.
- err  out  1  sticky protocol-error flag.
- err_code  out  3  code of the first error; holds until reset.
- refresh_count  out  16  AUTO_REFRESH commands accepted since init_done; wraps at 65535 to 0.

## Operation
- Commands are decoded from {cs,ras,cas,we}:
  - 1xxx INHIBIT and 0111 NOP are ignored.
  - 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE.
  - 0110 BURST_TERMINATE is ignored.
- Init FSM:
  - UNINIT: waits for PRECHARGE with A10=1, then goes to PRECHARGED.
  - PRECHARGED: counts AUTO_REFRESH commands.
  - LOAD_MODE with count >= INIT_REFRESH and a legal mode goes to READY and sets init_done.
  - Any ACTIVE/READ/WRITE before READY is error 1, as is an early LOAD_MODE.
- Mode register fields: A6:4 = CL (2 or 3 accepted), A2:0 = BL (must be 000), A9 = single-write.
  - Any other CL or BL is error 6; the mode is not updated.
  - Reload in READY is allowed only with all banks idle; otherwise error 5.
- Per bank: open flag, 12-bit row and an RCD counter.
  - ACTIVE to an open bank is error 4; otherwise it latches the row and sets open.
  - READ/WRITE to an idle bank is error 2.
  - READ/WRITE issued fewer than RCD edges after ACTIVE is error 3.
  - READ/WRITE with A10=1 closes the bank after the access.
- PRECHARGE: A10=1 closes all banks; A10=0 closes bank ba.
- WRITE: sd_data is sampled at the WRITE edge; each unmasked byte lane updates array[index].
- READ: array[index] is pushed into a 3-stage latency pipe. DQM is ignored for reads; the controller selects the byte.
- Once READY, AUTO_REFRESH with any bank open is error 5.
- Refresh interval monitor: in READY, a counter clears on each AUTO_REFRESH; exceeding TREFI_MAX is error 7, raised once.
- Any erroneous command is ignored. Only the first error code is latched.
- A WRITE arriving while read data is pending cancels the pending read; the bus is then not driven for it.

## Timing
- Reset values:
  - init_done=0, mode_cl=0, err=0, err_code=0, refresh_count=0.
  - All banks idle, latency pipe empty, sd_data Z, FSM in UNINIT.
  - Array contents are retained across reset.
- Reset asserted mid-read clears the pipe; sd_data is Z from the next cycle.
- Read latency: READ sampled at edge E drives sd_data from just after edge E+CL-1 until just after edge E+CL. The controller therefore samples valid data at edge E+CL.
- Reads on consecutive edges to different banks produce back-to-back data cycles.
- init_done, err and err_code update at the edge that samples the triggering command.
- The bank-closed state from auto-precharge is effective for commands at edge E+1 and later.

## Test plan
- Init: PRECHARGE A10=1, 8× AUTO_REFRESH, LOAD_MODE 0x220 -> init_done=1, mode_cl=2, err=0.
- ACTIVE ba=1 row=0x005 at E, WRITE col=0x12 data 0xBEEF dqm=00 A10=1 at E+1, ACTIVE again, READ at E+4 -> sd_data=0xBEEF driven during the cycle before edge E+6, Z otherwise.
- Write 0x1234 then 0xAB00 with dqm=01 to the same word, then read -> 0xAB34. Repeat with CL=3 -> data one cycle later.
- READ with A10=1, then READ on the same bank without ACTIVE -> err=1, err_code=2, no data driven.
- ACTIVE ba=0, then AUTO_REFRESH -> err_code=5, refresh_count unchanged. Separately, no refresh for 1249 cycles -> err_code=7.
- READ issued, then reset asserted at E+1 -> sd_data Z at E+2, init_done=0, and previously written data is still readable after re-init.
